// File: rtl/branch_seq_ctl_if.sv
// Sequencer <-> datapath bundle: IR/condition/memory status in, control strobes and status out.
// Carries no state of its own; the master modport belongs to the sequencer.
interface branch_seq_ctl_if;
    logic [31:0] ir;
    logic        con;
    logic        mem_ready;
    logic        pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
    logic        inc_pc, read, gra, grb, r_in, r_out, con_in, c_out, r15_in;
    logic [4:0]  alu_op;
    logic        run;
    logic        ill_op;
    logic [3:0]  state;

    modport master (
        input  ir, con, mem_ready,
        output pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in,
        output inc_pc, read, gra, grb, r_in, r_out, con_in, c_out, r15_in,
        output alu_op, run, ill_op, state
    );

    modport slave (
        output ir, con, mem_ready,
        input  pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in,
        input  inc_pc, read, gra, grb, r_in, r_out, con_in, c_out, r15_in,
        input  alu_op, run, ill_op, state
    );
endinterface

// File: rtl/branch_seq_ctl.sv
// Hardwired T-state sequencer for fetch, branch, jump and JAL (JAL only with BRANCH_LINK_EN).
// Latency: fetch 3 cycles plus 1 per memory wait; all outputs are registered Moore decodes.
// Backpressure: mem_ready low holds T1W; HALT is left only through clr.
module branch_seq_ctl (
    input  logic              clk,
    input  logic              clr,
    branch_seq_ctl_if.master  bus
);
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10011;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;
    localparam logic [4:0] ALU_ADD = 5'b00011;

`ifdef BRANCH_LINK_EN
    localparam logic JAL_EN = 1'b1;
`else
    localparam logic JAL_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_RST  = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T1W = 4'd3, S_T2 = 4'd4,
        S_T3   = 4'd5, S_T4 = 4'd6, S_T5 = 4'd7, S_T6  = 4'd8, S_HALT = 4'd9
    } state_t;

    typedef struct packed {
        logic pc_out, zlow_out, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in, y_in;
        logic inc_pc, read, gra, grb, r_in, r_out, con_in, c_out, r15_in;
    } strobe_t;

    state_t     state_d, state_q;
    logic [4:0] op_d, op_q;
    strobe_t    sb_d, sb_q;
    logic [4:0] alu_d, alu_q;
    logic       run_d, run_q;
    logic       ill_d, ill_q;
    logic       ir_unused;

    assign ir_unused = ^bus.ir[26:0];

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            S_RST:  state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1:   state_d = bus.mem_ready ? S_T2 : S_T1W;
            S_T1W:  if (bus.mem_ready) state_d = S_T2;
            S_T2: begin
                state_d = S_T3;
                op_d    = bus.ir[31:27];
            end
            S_T3: begin
                case (op_q)
                    OP_BR:   state_d = S_T4;
                    OP_JAL:  state_d = JAL_EN ? S_T4 : S_T0;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_T0;
                endcase
            end
            S_T4:   state_d = (op_q == OP_BR) ? S_T5 : S_T0;
            S_T5:   state_d = bus.con ? S_T6 : S_T0;
            S_T6:   state_d = S_T0;
            S_HALT: state_d = S_HALT;
            default: state_d = S_RST;
        endcase

        // Outputs are decoded from the next state so the registered copy matches the current state.
        sb_d  = '0;
        alu_d = 5'b00000;
        ill_d = 1'b0;
        run_d = (state_d != S_RST) && (state_d != S_HALT);
        case (state_d)
            S_T0: begin
                sb_d.pc_out = 1'b1; sb_d.mar_in = 1'b1; sb_d.inc_pc = 1'b1; sb_d.z_in = 1'b1;
            end
            S_T1: begin
                sb_d.zlow_out = 1'b1; sb_d.pc_in = 1'b1; sb_d.read = 1'b1; sb_d.mdr_in = 1'b1;
            end
            S_T1W: begin
                sb_d.read = 1'b1; sb_d.mdr_in = 1'b1;
            end
            S_T2: begin
                sb_d.mdr_out = 1'b1; sb_d.ir_in = 1'b1;
            end
            S_T3: begin
                case (op_d)
                    OP_BR:  begin sb_d.gra = 1'b1; sb_d.r_out = 1'b1; sb_d.con_in = 1'b1; end
                    OP_JR:  begin sb_d.gra = 1'b1; sb_d.r_out = 1'b1; sb_d.pc_in  = 1'b1; end
                    OP_JAL: begin
                        sb_d.pc_out = JAL_EN;
                        sb_d.r15_in = JAL_EN;
                        ill_d       = !JAL_EN;
                    end
                    OP_NOP, OP_HALT: ;
                    default: ill_d = 1'b1;
                endcase
            end
            S_T4: begin
                if (op_d == OP_BR) begin
                    sb_d.pc_out = 1'b1; sb_d.y_in = 1'b1;
                end else begin
                    sb_d.gra = 1'b1; sb_d.r_out = 1'b1; sb_d.pc_in = 1'b1;
                end
            end
            S_T5: begin
                sb_d.c_out = 1'b1; sb_d.z_in = 1'b1; alu_d = ALU_ADD;
            end
            S_T6: begin
                sb_d.zlow_out = 1'b1; sb_d.pc_in = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_RST;
            op_q    <= 5'b00000;
            sb_q    <= '0;
            alu_q   <= 5'b00000;
            run_q   <= 1'b0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            sb_q    <= sb_d;
            alu_q   <= alu_d;
            run_q   <= run_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.pc_out   = sb_q.pc_out;
    assign bus.zlow_out = sb_q.zlow_out;
    assign bus.mdr_out  = sb_q.mdr_out;
    assign bus.mar_in   = sb_q.mar_in;
    assign bus.z_in     = sb_q.z_in;
    assign bus.pc_in    = sb_q.pc_in;
    assign bus.mdr_in   = sb_q.mdr_in;
    assign bus.ir_in    = sb_q.ir_in;
    assign bus.y_in     = sb_q.y_in;
    assign bus.inc_pc   = sb_q.inc_pc;
    assign bus.read     = sb_q.read;
    assign bus.gra      = sb_q.gra;
    assign bus.grb      = sb_q.grb;
    assign bus.r_in     = sb_q.r_in;
    assign bus.r_out    = sb_q.r_out;
    assign bus.con_in   = sb_q.con_in;
    assign bus.c_out    = sb_q.c_out;
    assign bus.r15_in   = sb_q.r15_in;
    assign bus.alu_op   = alu_q;
    assign bus.run      = run_q;
    assign bus.ill_op   = ill_q;
    assign bus.state    = state_q;
endmodule
